fadd_pipe: RTL
==============

FADD_PIPE -- requirements
Module: fadd_pipe

Interface
REQ-001 Parameter EW, default 8, exponent width in bits; legal range 4..11.
REQ-002 Parameter MW, default 23, stored mantissa width in bits; legal range 4..52.
REQ-003 Parameter TW, default 4, sideband tag width; legal range 1..16.
REQ-004 Port clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port rstn  input  1  reset, asynchronous, active-low.
REQ-006 Port in_valid  input  1  operand pair valid.
REQ-007 Port in_ready  output  1  block accepts the operand pair this cycle.
REQ-008 Port x1  input  1+EW+MW  operand A as {sign, exponent, mantissa}.
REQ-009 Port x2  input  1+EW+MW  operand B, same format.
REQ-010 Port sub  input  1  0 = A+B, 1 = A-B (sign of B inverted before processing).
REQ-011 Port in_tag  input  TW  sideband, returned unchanged with the result.
REQ-012 Port out_valid  output  1  result valid.
REQ-013 Port out_ready  input  1  consumer accepts the result.
REQ-014 Port y  output  1+EW+MW  result.
REQ-015 Port out_tag  output  TW  tag of the operation producing y.

Function
REQ-016 Pipeline SHALL be 3 stages: S1 swap/align, S2 add/sub plus leading-zero count, S3 normalise/round/pack; with no stall, latency is exactly 3 cycles from accept to out_valid.
REQ-017 Transfer in on in_valid&in_ready; transfer out on out_valid&out_ready.
REQ-018 in_ready SHALL equal !(out_valid & !out_ready); while it is low, every stage holds its contents.
REQ-019 Bubbles SHALL advance while stalled output is absent; throughput is 1 op/cycle; results leave in acceptance order; no op is dropped or duplicated.
REQ-020 Denormal inputs (exp==0) SHALL be flushed to signed zero; denormal results are never produced.
REQ-021 The larger magnitude (compare {exp,mant}) SHALL become A'; the smaller is right-shifted by the exponent difference, keeping guard, round and sticky bits; a shift >= MW+3 leaves sticky only.
REQ-022 Effective operation is addition if the signs are equal (after sub), else subtraction A'-B'; the result sign is the sign of A'.
REQ-023 Rounding SHALL be round-to-nearest-even; a mantissa carry-out from rounding increments the exponent.
REQ-024 An exact cancellation result SHALL be +0; zero+zero SHALL give sign = sA & sB_eff.
REQ-025 Normalised exponent >= 2^EW-1 SHALL give signed infinity (exp all ones, mant 0); exponent <= 0 SHALL give signed zero.
REQ-026 Exponent all ones on input is infinity (mantissa ignored); inf op finite = that inf; inf+inf of equal sign = that inf; opposite-sign infinities = canonical NaN {0, all ones, 1 followed by zeros}.
REQ-027 Tag SHALL travel with its operation through all stages.

Reset
REQ-028 rstn low SHALL asynchronously clear all stage valid bits, out_valid, y and out_tag to 0; in_ready is 1 during reset.
REQ-029 Operations in flight at reset SHALL be discarded; the first accept after rstn rises produces a result exactly 3 cycles later.

Verification
REQ-030 x1=0x3F800000, x2=0x3F800000, sub=0, tag=5 -> 3 cycles later y=0x40000000, out_tag=5.
REQ-031 x1=0x40400000, x2=0x3F800000, sub=1 -> y=0x40000000; x1=x2=0x3F800000, sub=1 -> y=0x00000000.
REQ-032 Rounding: 0x3F800000+0x33800000 -> 0x3F800000 (tie to even); 0x3F800001+0x33800000 -> 0x3F800002.
REQ-033 Specials: 0x7F7FFFFF+0x7F7FFFFF -> 0x7F800000; 0x7F800000+0xFF800000 -> 0x7FC00000; 0x00400000+0x3F800000 -> 0x3F800000.
REQ-034 Stream 6 ops back-to-back with out_ready low for 2 cycles mid-stream -> in_ready low exactly while out_valid&!out_ready; all 6 results arrive in order with correct tags.
REQ-035 Pull rstn low for 1 cycle with 3 ops in flight -> out_valid drops to 0 immediately and no stale result appears; an op issued afterwards completes in 3 cycles.

Source files
------------

// File: rtl/fadd_pipe.sv
// Three-stage pipelined floating-point add/subtract (flush-to-zero, round-to-nearest-even) with a sideband tag.
// Latency: 3 cycles from accept to out_valid; throughput 1 op/cycle.
// Backpressure: the whole pipe freezes while a result waits unaccepted; in_ready is low exactly then.
module fadd_pipe #(
    parameter int EW = 8,
    parameter int MW = 23,
    parameter int TW = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [EW+MW:0]   x1,
    input  logic [EW+MW:0]   x2,
    input  logic             sub,
    input  logic [TW-1:0]    in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [EW+MW:0]   y,
    output logic [TW-1:0]    out_tag
);
    localparam int W   = 1 + EW + MW;
    localparam int FW  = MW + 4;            // hidden + mantissa + guard/round/sticky
    localparam int SW  = MW + 5;            // FW plus carry-out
    localparam int LZW = $clog2(SW + 1);
    localparam int XW  = EW + 8;            // signed exponent headroom for normalisation
    localparam int DW  = EW + 7;
    localparam logic [DW-1:0] SHMAX = DW'(MW + 3);
    localparam logic [XW-1:0] EMAX  = XW'((1 << EW) - 1);

    typedef struct packed {
        logic          vld;
        logic [TW-1:0] tag;
        logic          sign;
        logic [EW-1:0] exp;
        logic [MW:0]   ma;
        logic [FW-1:0] mb;
        logic          eff_sub;
        logic          special;
        logic [W-1:0]  sp_res;
    } s1_t;

    typedef struct packed {
        logic           vld;
        logic [TW-1:0]  tag;
        logic           sign;
        logic [EW-1:0]  exp;
        logic [SW-1:0]  sum;
        logic [LZW-1:0] lzc;
        logic           special;
        logic [W-1:0]   sp_res;
    } s2_t;

    s1_t s1, s1_n;
    s2_t s2, s2_n;

    function automatic logic [LZW-1:0] lzc_f(input logic [SW-1:0] v);
        lzc_f = LZW'(SW);
        for (int i = 0; i < SW; i++)
            if (v[i]) lzc_f = LZW'(SW - 1 - i);
    endfunction

    assign in_ready = !(out_valid && !out_ready);

    // S1: unpack, flush denormals, resolve specials, order by magnitude, align smaller operand
    logic             sa, sb, a_inf, b_inf, a_zero, b_zero, swap, lost;
    logic [EW+MW-1:0] mag_a, mag_b, mag_big, mag_sml;
    logic [EW-1:0]    d;
    logic [MW:0]      m_sml;
    logic [FW-1:0]    ext, shd, al;
    logic [W-1:0]     sp;

    always_comb begin
        sa      = x1[EW+MW];
        sb      = x2[EW+MW] ^ sub;
        a_inf   = &x1[EW+MW-1:MW];
        b_inf   = &x2[EW+MW-1:MW];
        a_zero  = ~|x1[EW+MW-1:MW];
        b_zero  = ~|x2[EW+MW-1:MW];
        mag_a   = a_zero ? '0 : x1[EW+MW-1:0];
        mag_b   = b_zero ? '0 : x2[EW+MW-1:0];
        swap    = mag_b > mag_a;
        mag_big = swap ? mag_b : mag_a;
        mag_sml = swap ? mag_a : mag_b;
        d       = mag_big[EW+MW-1:MW] - mag_sml[EW+MW-1:MW];
        m_sml   = {|mag_sml[EW+MW-1:MW], mag_sml[MW-1:0]};
        ext     = {m_sml, 3'b000};
        shd     = ext >> d;
        lost    = |(ext & ~({FW{1'b1}} << d));
        if ({{(DW-EW){1'b0}}, d} >= SHMAX)
            al = {{(FW-1){1'b0}}, |m_sml};
        else
            al = {shd[FW-1:1], shd[0] | lost};

        if (a_inf && b_inf)
            sp = (sa == sb) ? {sa, {EW{1'b1}}, {MW{1'b0}}}
                            : {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};
        else if (a_inf)
            sp = {sa, {EW{1'b1}}, {MW{1'b0}}};
        else if (b_inf)
            sp = {sb, {EW{1'b1}}, {MW{1'b0}}};
        else
            sp = {sa & sb, {(W-1){1'b0}}};

        s1_n.vld     = in_valid;
        s1_n.tag     = in_tag;
        s1_n.sign    = swap ? sb : sa;
        s1_n.exp     = mag_big[EW+MW-1:MW];
        s1_n.ma      = {|mag_big[EW+MW-1:MW], mag_big[MW-1:0]};
        s1_n.mb      = al;
        s1_n.eff_sub = sa ^ sb;
        s1_n.special = a_inf | b_inf | (a_zero & b_zero);
        s1_n.sp_res  = sp;
    end

    // S2: magnitude add/subtract (never negative since A' >= B') and leading-zero count
    logic [SW-1:0] op_a, op_b, sum;

    always_comb begin
        op_a         = {1'b0, s1.ma, 3'b000};
        op_b         = {1'b0, s1.mb};
        sum          = s1.eff_sub ? op_a - op_b : op_a + op_b;
        s2_n.vld     = s1.vld;
        s2_n.tag     = s1.tag;
        s2_n.sign    = s1.sign;
        s2_n.exp     = s1.exp;
        s2_n.sum     = sum;
        s2_n.lzc     = lzc_f(sum);
        s2_n.special = s1.special;
        s2_n.sp_res  = s1.sp_res;
    end

    // S3: normalise so the leading one sits at the carry position, then RNE round and pack
    logic [SW-1:0] norm;
    logic [MW:0]   rnd;
    logic          rup, rcarry;
    logic [XW-1:0] e_res;
    logic [W-1:0]  y_n;

    always_comb begin
        norm   = s2.sum << s2.lzc;
        rup    = norm[3] & ((|norm[2:0]) | norm[4]);
        rnd    = norm[SW-1:4] + (MW+1)'(rup);
        // a rounding overflow wraps the hidden bit to 0; the fraction is then already all zeros
        rcarry = ~rnd[MW];
        e_res  = XW'(s2.exp) + XW'(1) - XW'(s2.lzc) + XW'(rcarry);
        if (s2.special)
            y_n = s2.sp_res;
        else if (~|s2.sum)
            y_n = '0;
        else if (!e_res[XW-1] && (e_res >= EMAX))
            y_n = {s2.sign, {EW{1'b1}}, {MW{1'b0}}};
        else if (e_res[XW-1] || (~|e_res))
            y_n = {s2.sign, {(W-1){1'b0}}};
        else
            y_n = {s2.sign, e_res[EW-1:0], rnd[MW-1:0]};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1        <= '0;
            s2        <= '0;
            out_valid <= 1'b0;
            y         <= '0;
            out_tag   <= '0;
        end else if (in_ready) begin
            s1        <= s1_n;
            s2        <= s2_n;
            out_valid <= s2.vld;
            y         <= y_n;
            out_tag   <= s2.tag;
        end
    end

endmodule
